// File: rtl/cheat_pgm_sched.sv
// cheat_pgm_sched: queues MCU program requests and issues them to the cheat
// unit's program port as single-cycle writes, only in bus-safe cycles.
//
// Build option: define CHEAT_SAFE_SWAP_EN to mask an enabled ROM patch slot
// off around its rewrite (MASK_OFF -> WRITE -> MASK_ON). Without it every
// entry goes straight IDLE -> WRITE -> IDLE.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mcu_req/idx/data      MCU write request (accepted when mcu_req & mcu_rdy)
//   mcu_rdy               FIFO not full
//   ovf_clr, ovf          sticky overflow flag and its clear
//   busy                  FIFO non-empty or sequencer not idle
//   SNES_ADDR             SNES A-bus address (vector page blocks writes)
//   SNES_cycle_start      SNES cycle start strobe (blocks writes)
//   snescmd_wr_block      snescmd write in progress (blocks writes)
//   pgm_we/pgm_idx/pgm_in registered program port to the cheat unit
module cheat_pgm_sched #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mcu_req,
  input  logic [2:0]  mcu_idx,
  input  logic [31:0] mcu_data,
  output logic        mcu_rdy,
  input  logic        ovf_clr,
  output logic        ovf,
  output logic        busy,
  input  logic [23:0] SNES_ADDR,
  input  logic        SNES_cycle_start,
  input  logic        snescmd_wr_block,
  output logic        pgm_we,
  output logic [2:0]  pgm_idx,
  output logic [31:0] pgm_in
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_MASK_OFF, S_WRITE, S_MASK_ON} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    st_idx_q, st_idx_d;
  logic [31:0]   st_data_q, st_data_d;
  logic          swap_q, swap_d;
  logic [5:0]    mask_sh_q, mask_sh_d;
  logic          ovf_q, ovf_d;
  logic          pgm_we_q, pgm_we_d;
  logic [2:0]    pgm_idx_q, pgm_idx_d;
  logic [31:0]   pgm_in_q, pgm_in_d;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic          full, empty, safe, push, pop, swap_hit;
  logic          unused_addr_lsb;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign push  = mcu_req & ~full;

  // Vector page 00FFE0-00FFFF is fetched by the CPU on interrupts; never disturb it.
  assign safe = ~SNES_cycle_start & ~snescmd_wr_block & ~(SNES_ADDR[23:5] == 19'h007FF);
  assign unused_addr_lsb = ^SNES_ADDR[4:0];

`ifdef CHEAT_SAFE_SWAP_EN
  logic [7:0] mask_ext;
  assign mask_ext = {2'b00, mask_sh_q};
  // Slot writes to a currently enabled slot are bracketed by mask off/on.
  assign swap_hit = (head.idx < 3'd6) & mask_ext[head.idx];
`else
  assign swap_hit = 1'b0;
`endif

  // Sequencer next-state and program-port outputs.
  always_comb begin
    state_d   = state_q;
    st_idx_d  = st_idx_q;
    st_data_d = st_data_q;
    swap_d    = swap_q;
    mask_sh_d = mask_sh_q;
    pgm_we_d  = 1'b0;
    pgm_idx_d = pgm_idx_q;
    pgm_in_d  = pgm_in_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          st_idx_d  = head.idx;
          st_data_d = head.data;
          swap_d    = swap_hit;
          state_d   = swap_hit ? S_MASK_OFF : S_WRITE;
        end
      end
      S_MASK_OFF: begin
        if (safe) begin
          pgm_we_d  = 1'b1;
          pgm_idx_d = 3'd6;
          pgm_in_d  = {26'b0, mask_sh_q & ~(6'b1 << st_idx_q)};
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (safe) begin
          pgm_we_d  = 1'b1;
          pgm_idx_d = st_idx_q;
          pgm_in_d  = st_data_q;
          if (st_idx_q == 3'd6) mask_sh_d = st_data_q[5:0];
          state_d   = swap_q ? S_MASK_ON : S_IDLE;
        end
      end
      S_MASK_ON: begin
        if (safe) begin
          pgm_we_d  = 1'b1;
          pgm_idx_d = 3'd6;
          pgm_in_d  = {26'b0, mask_sh_q};
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers, occupancy and overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Set has priority over clear.
    ovf_d = (mcu_req & full) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      st_idx_q  <= '0;
      st_data_q <= '0;
      swap_q    <= 1'b0;
      mask_sh_q <= '0;
      ovf_q     <= 1'b0;
      pgm_we_q  <= 1'b0;
      pgm_idx_q <= '0;
      pgm_in_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      st_idx_q  <= st_idx_d;
      st_data_q <= st_data_d;
      swap_q    <= swap_d;
      mask_sh_q <= mask_sh_d;
      ovf_q     <= ovf_d;
      pgm_we_q  <= pgm_we_d;
      pgm_idx_q <= pgm_idx_d;
      pgm_in_q  <= pgm_in_d;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push && rst_n) mem_q[wr_ptr_q] <= '{idx: mcu_idx, data: mcu_data};
  end

  assign mcu_rdy = ~full;
  assign busy    = ~empty | (state_q != S_IDLE);
  assign ovf     = ovf_q;
  assign pgm_we  = pgm_we_q;
  assign pgm_idx = pgm_idx_q;
  assign pgm_in  = pgm_in_q;

endmodule

// File: tb/tb_cheat_pgm_sched.sv
// Self-checking bench for cheat_pgm_sched: directed sequences, a table of
// bus-safety patterns, and random traffic checked against a queue model of
// the expected program-port pulses.
module tb_cheat_pgm_sched;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mcu_req;
  logic [2:0]  mcu_idx;
  logic [31:0] mcu_data;
  logic        mcu_rdy;
  logic        ovf_clr;
  logic        ovf;
  logic        busy;
  logic [23:0] SNES_ADDR;
  logic        SNES_cycle_start;
  logic        snescmd_wr_block;
  logic        pgm_we;
  logic [2:0]  pgm_idx;
  logic [31:0] pgm_in;

  always #5 clk = ~clk;

  cheat_pgm_sched #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mcu_req          (mcu_req),
    .mcu_idx          (mcu_idx),
    .mcu_data         (mcu_data),
    .mcu_rdy          (mcu_rdy),
    .ovf_clr          (ovf_clr),
    .ovf              (ovf),
    .busy             (busy),
    .SNES_ADDR        (SNES_ADDR),
    .SNES_cycle_start (SNES_cycle_start),
    .snescmd_wr_block (snescmd_wr_block),
    .pgm_we           (pgm_we),
    .pgm_idx          (pgm_idx),
    .pgm_in           (pgm_in)
  );

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
    int          cyc;
  } pulse_t;

  typedef struct {
    logic [23:0] addr;
    logic        cs;
    logic        blk;
    int          hold;
    logic        ok;
  } gate_t;

  pulse_t     exp_q[$];
  pulse_t     plog[$];
  pulse_t     want[$];
  gate_t      gt[9];
  logic [5:0] m_mask = '0;
  logic       ovf_m = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected pulses for one accepted request, from the documented rules.
  function automatic void model_push(input logic [2:0] idx, input logic [31:0] d);
    int  i;
    logic swp;
    i = int'(idx);
`ifdef CHEAT_SAFE_SWAP_EN
    swp = (i < 6) ? m_mask[i] : 1'b0;
`else
    swp = 1'b0;
`endif
    if (swp) exp_q.push_back('{3'd6, {26'd0, m_mask & ~(6'b1 << idx)}, 0});
    exp_q.push_back('{idx, d, 0});
    if (swp) exp_q.push_back('{3'd6, {26'd0, m_mask}, 0});
    if (idx == 3'd6) m_mask = d[5:0];
  endfunction

  task automatic step();
    logic        acc, sf, rs, ovf_n;
    logic [2:0]  ai;
    logic [31:0] ad;
    pulse_t      p;
    acc   = mcu_req && mcu_rdy && rst_n;
    ai    = mcu_idx;
    ad    = mcu_data;
    rs    = rst_n;
    sf    = !SNES_cycle_start && !snescmd_wr_block && (SNES_ADDR[23:5] != 19'h007FF);
    ovf_n = rs ? ((mcu_req && !mcu_rdy) || (ovf_m && !ovf_clr)) : 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (!rs) begin
      exp_q.delete();
      m_mask = '0;
    end else if (acc) begin
      model_push(ai, ad);
    end
    ovf_m = ovf_n;
    chk("ovf_track", 64'(ovf), 64'(ovf_m));
    if (pgm_we === 1'b1) begin
      chk("we_after_unsafe", 64'(sf), 64'd1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got idx %0d data %0h want no pulse", pgm_idx, pgm_in);
      end else begin
        p = exp_q.pop_front();
        chk("pulse_idx", 64'(pgm_idx), 64'(p.idx));
        chk("pulse_data", 64'(pgm_in), 64'(p.data));
      end
      plog.push_back('{pgm_idx, pgm_in, cyc});
    end
  endtask

  task automatic set_safe(input logic s);
    SNES_ADDR        = 24'h008000;
    SNES_cycle_start = !s;
    snescmd_wr_block = 1'b0;
  endtask

  task automatic push(input logic [2:0] idx, input logic [31:0] d);
    mcu_req  = 1'b1;
    mcu_idx  = idx;
    mcu_data = d;
    step();
    mcu_req  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nacc;
    int n;
    int r;

    gt[0] = '{24'h00FFEA, 1'b0, 1'b0, 10, 1'b0};
    gt[1] = '{24'h00FFE0, 1'b0, 1'b0, 3,  1'b0};
    gt[2] = '{24'h00FFFF, 1'b0, 1'b0, 3,  1'b0};
    gt[3] = '{24'h00FFDF, 1'b0, 1'b0, 3,  1'b1};
    gt[4] = '{24'h01FFE0, 1'b0, 1'b0, 3,  1'b1};
    gt[5] = '{24'h80FFEA, 1'b0, 1'b0, 3,  1'b1};
    gt[6] = '{24'h008000, 1'b1, 1'b0, 4,  1'b0};
    gt[7] = '{24'h008000, 1'b0, 1'b1, 4,  1'b0};
    gt[8] = '{24'h008000, 1'b0, 1'b0, 2,  1'b1};

    rst_n    = 1'b0;
    mcu_req  = 1'b0;
    mcu_idx  = '0;
    mcu_data = '0;
    ovf_clr  = 1'b0;
    set_safe(1'b1);
    step();
    step();
    chk("rst_we",   64'(pgm_we),  64'd0);
    chk("rst_idx",  64'(pgm_idx), 64'd0);
    chk("rst_in",   64'(pgm_in),  64'd0);
    chk("rst_ovf",  64'(ovf),     64'd0);
    chk("rst_busy", 64'(busy),    64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_rdy", 64'(mcu_rdy), 64'd1);

    // Single global-flags write: pop next edge, pulse the edge after.
    plog.delete();
    push(3'd7, 32'h0000_0001);
    step();
    chk("t1_lat_we0", 64'(pgm_we), 64'd0);
    step();
    chk("t1_we",   64'(pgm_we),  64'd1);
    chk("t1_idx",  64'(pgm_idx), 64'd7);
    chk("t1_in",   64'(pgm_in),  64'h1);
    chk("t1_busy", 64'(busy),    64'd0);
    step();
    chk("t1_we_off", 64'(pgm_we), 64'd0);
    chk("t1_count", 64'(plog.size()), 64'd1);

    // Enable all slots, then rewrite enabled slot 2.
    plog.delete();
    mcu_req  = 1'b1;
    mcu_idx  = 3'd6;
    mcu_data = 32'h0000_003F;
    step();
    mcu_idx  = 3'd2;
    mcu_data = 32'h00C0_1234;
    step();
    mcu_req  = 1'b0;
    repeat (12) step();
`ifdef CHEAT_SAFE_SWAP_EN
    want = '{'{3'd6, 32'h3F, 0}, '{3'd6, 32'h3B, 2}, '{3'd2, 32'h00C0_1234, 3}, '{3'd6, 32'h3F, 4}};
`else
    want = '{'{3'd6, 32'h3F, 0}, '{3'd2, 32'h00C0_1234, 2}};
`endif
    chk("t2_count", 64'(plog.size()), 64'(want.size()));
    for (int i = 0; i < want.size() && i < plog.size(); i++) begin
      chk("t2_idx",  64'(plog[i].idx),  64'(want[i].idx));
      chk("t2_data", 64'(plog[i].data), 64'(want[i].data));
      chk("t2_gap",  64'(plog[i].cyc - plog[0].cyc), 64'(want[i].cyc));
    end
    chk("t2_busy", 64'(busy), 64'd0);

    // Bus-safety table: entry parked in WRITE, then the pattern is applied.
    for (int i = 0; i < 9; i++) begin
      set_safe(1'b0);
      push(3'd7, 32'hA000_0000 + 32'(i));
      step();
      SNES_ADDR        = gt[i].addr;
      SNES_cycle_start = gt[i].cs;
      snescmd_wr_block = gt[i].blk;
      for (int k = 0; k < gt[i].hold; k++) begin
        step();
        chk("gate_we", 64'(pgm_we), 64'(gt[i].ok && k == 0));
      end
      set_safe(1'b1);
      step();
      chk("gate_release", 64'(pgm_we), 64'(!gt[i].ok));
      step();
      chk("gate_busy", 64'(busy), 64'd0);
    end

    // Overflow: one entry goes to staging, DEPTH fill the FIFO.
    set_safe(1'b0);
    nacc = 0;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      mcu_req  = 1'b1;
      mcu_idx  = 3'd7;
      mcu_data = 32'hB0 + 32'(i);
      if (mcu_rdy) nacc++;
      step();
    end
    chk("ovf_accepts", 64'(nacc), 64'(DEPTH + 1));
    chk("ovf_rdy", 64'(mcu_rdy), 64'd0);
    chk("ovf_set", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    step();
    chk("ovf_set_wins", 64'(ovf), 64'd1);
    mcu_req = 1'b0;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(ovf), 64'd0);
    plog.delete();
    set_safe(1'b1);
    repeat (3 * (DEPTH + 1) + 6) step();
    chk("ovf_drain_count", 64'(plog.size()), 64'(DEPTH + 1));
    for (int i = 0; i < plog.size(); i++)
      chk("ovf_drain_order", 64'(plog[i].data), 64'(32'hB0 + 32'(i)));
    chk("ovf_drain_rdy", 64'(mcu_rdy), 64'd1);

    // Reset while a slot write is stalled in WRITE.
    push(3'd6, 32'h0000_003F);
    repeat (4) step();
    plog.delete();
    push(3'd2, 32'h5555_0002);
    step();
`ifdef CHEAT_SAFE_SWAP_EN
    step();
    chk("t5_maskoff_cnt", 64'(plog.size()), 64'd1);
`endif
    set_safe(1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("t5_rst_we",   64'(pgm_we),  64'd0);
    chk("t5_rst_idx",  64'(pgm_idx), 64'd0);
    chk("t5_rst_in",   64'(pgm_in),  64'd0);
    chk("t5_rst_ovf",  64'(ovf),     64'd0);
    chk("t5_rst_busy", 64'(busy),    64'd0);
    rst_n = 1'b1;
    set_safe(1'b1);
    step();
    chk("t5_rdy", 64'(mcu_rdy), 64'd1);
    plog.delete();
    push(3'd2, 32'h0000_ABCD);
    repeat (6) step();
    chk("t5_count", 64'(plog.size()), 64'd1);
    if (plog.size() > 0) begin
      chk("t5_idx",  64'(plog[0].idx),  64'd2);
      chk("t5_data", 64'(plog[0].data), 64'h0000_ABCD);
    end

    // Random traffic against the pulse queue model.
    for (int c = 0; c < 600; c++) begin
      mcu_req  = 1'($urandom % 2);
      mcu_idx  = ($urandom % 4 == 0) ? 3'd6 : 3'($urandom % 8);
      mcu_data = $urandom;
      SNES_cycle_start = ($urandom % 4 == 0);
      snescmd_wr_block = ($urandom % 7 == 0);
      r = int'($urandom % 5);
      case (r)
        0:       SNES_ADDR = 24'h00FFE0 + 24'($urandom % 32);
        1:       SNES_ADDR = 24'h00FFDF;
        2:       SNES_ADDR = 24'h01FFE0;
        default: SNES_ADDR = 24'($urandom);
      endcase
      ovf_clr = ($urandom % 10 == 0);
      step();
    end
    mcu_req = 1'b0;
    ovf_clr = 1'b0;
    set_safe(1'b1);
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_busy",  64'(busy), 64'd0);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
